// File: rtl/master_spi_multi.sv
// SPI master on the I/O strobe bus: programmable SCLK divider, all four SPI modes,
// NCS indexed chip selects, read-ahead and a one-deep pending-command slot.
module master_spi_multi #(
    parameter int unsigned NCS         = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       A,
    input  logic [7:0]       D_in,
    output logic [7:0]       D_out,
    output logic             DDIR,
    output logic             WAIT,
    input  logic             IOWR,
    input  logic             IORD,
    output logic [NCS-1:0]   SS,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e             state_q;

    // Strobe synchronisers; stage 3 is only kept for rising-edge detection.
    logic               iord_s1_q, iord_s2_q, iord_s3_q;
    logic               iowr_s1_q, iowr_s2_q, iowr_s3_q;
    logic               both_q;
    logic [1:0]         a_q;
    logic [7:0]         d_q;

    logic               cpol_q, cpha_q, autord_q;
    logic [3:0]         cs_idx_q;
    logic [DIV_W-1:0]   div_q;

    logic               pend_q, pend_last_q, overrun_q;
    logic [7:0]         pend_data_q;

    logic [7:0]         tx_q, rx_sh_q, rx_q;
    logic [DIV_W-1:0]   cnt_q, div_t_q;
    logic [4:0]         edge_q;
    logic               cpol_t_q, cpha_t_q, last_q;
    logic               sclk_q, mosi_q;
    logic [NCS-1:0]     ss_q;

    logic               busy;
    logic               rd_rise, wr_rise;
    logic               cmd_xfer, cmd_last;
    logic [7:0]         cmd_data;
    logic               tick, done, leading, samp_edge, shift_edge;
    logic               start_pend, start_cmd, queue_cmd, start;
    logic [7:0]         start_data;
    logic               start_last;
    logic               cs_valid;
    logic [NCS-1:0]     sel_n;

    assign busy     = (state_q == StXfer);
    // A release that follows a both-strobes-low period is not a command.
    assign rd_rise  = iord_s2_q && !iord_s3_q && !both_q && iowr_s2_q;
    assign wr_rise  = iowr_s2_q && !iowr_s3_q && !both_q && iord_s2_q;

    assign cmd_xfer = (wr_rise && !a_q[1]) || (rd_rise && (a_q == 2'd0) && autord_q);
    assign cmd_data = wr_rise ? d_q : 8'hFF;
    assign cmd_last = wr_rise && a_q[0];

    assign tick       = busy && (cnt_q == div_t_q);
    assign done       = tick && (edge_q == 5'd16);
    assign leading    = !edge_q[0];
    assign samp_edge  = tick && !done && (leading ^ cpha_t_q);
    assign shift_edge = tick && !done && !(leading ^ cpha_t_q);

    assign start_pend = done && pend_q;
    assign start_cmd  = cmd_xfer && (!busy || (done && !pend_q));
    assign queue_cmd  = cmd_xfer && !start_cmd;
    assign start      = start_pend || start_cmd;
    assign start_data = start_pend ? pend_data_q : cmd_data;
    assign start_last = start_pend ? pend_last_q : cmd_last;

    assign cs_valid   = (32'(d_q[7:4]) < NCS);

    always_comb begin
        sel_n = '1;
        for (int unsigned i = 0; i < NCS; i++) begin
            if (i == 32'(cs_idx_q)) sel_n[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            iord_s1_q   <= 1'b1;
            iord_s2_q   <= 1'b1;
            iord_s3_q   <= 1'b1;
            iowr_s1_q   <= 1'b1;
            iowr_s2_q   <= 1'b1;
            iowr_s3_q   <= 1'b1;
            both_q      <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            autord_q    <= 1'b0;
            cs_idx_q    <= '0;
            div_q       <= DIV_W'(DEFAULT_DIV);
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_data_q <= '0;
            overrun_q   <= 1'b0;
            tx_q        <= '0;
            rx_sh_q     <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            div_t_q     <= '0;
            edge_q      <= '0;
            cpol_t_q    <= 1'b0;
            cpha_t_q    <= 1'b0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_q        <= '1;
        end else begin
            iord_s1_q <= IORD;
            iord_s2_q <= iord_s1_q;
            iord_s3_q <= iord_s2_q;
            iowr_s1_q <= IOWR;
            iowr_s2_q <= iowr_s1_q;
            iowr_s3_q <= iowr_s2_q;

            if (!iord_s2_q && !iowr_s2_q) begin
                both_q <= 1'b1;
            end else if (iord_s2_q && iowr_s2_q) begin
                both_q <= 1'b0;
            end

            if (!iord_s2_q || !iowr_s2_q) begin
                a_q <= A;
                d_q <= D_in;
            end

            // Bit engine
            if (busy) begin
                cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
                if (tick && !done) begin
                    sclk_q <= ~sclk_q;
                    edge_q <= edge_q + 5'd1;
                end
                if (samp_edge) rx_sh_q <= {rx_sh_q[6:0], MISO};
                if (shift_edge) begin
                    mosi_q <= cpha_t_q ? tx_q[7] : tx_q[6];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end
                if (done) begin
                    state_q <= StIdle;
                    rx_q    <= rx_sh_q;
                    sclk_q  <= cpol_t_q;
                    // A held select whose index was retargeted mid-transfer is dropped too.
                    if (last_q || (ss_q != sel_n)) ss_q <= '1;
                end
            end else begin
                sclk_q <= cpol_q;
            end

            if (wr_rise) begin
                case (a_q)
                    2'd2: begin
                        cpol_q   <= d_q[0];
                        cpha_q   <= d_q[1];
                        autord_q <= d_q[2];
                        if (!busy) sclk_q <= d_q[0];
                        if (cs_valid) begin
                            cs_idx_q <= d_q[7:4];
                            if ((d_q[7:4] != cs_idx_q) && !busy) ss_q <= '1;
                        end
                    end
                    2'd3:    div_q <= d_q[DIV_W-1:0];
                    default: ;
                endcase
            end

            if (rd_rise && (a_q == 2'd2)) overrun_q <= 1'b0;
            if (rd_rise && (a_q == 2'd1) && !busy) ss_q <= '1;

            if (queue_cmd) begin
                if (pend_q && !start_pend) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_data_q <= cmd_data;
                    pend_last_q <= cmd_last;
                end
            end else if (start_pend) begin
                pend_q <= 1'b0;
            end

            if (start) begin
                state_q  <= StXfer;
                tx_q     <= start_data;
                mosi_q   <= start_data[7];
                rx_sh_q  <= '0;
                cnt_q    <= '0;
                edge_q   <= '0;
                cpol_t_q <= cpol_q;
                cpha_t_q <= cpha_q;
                div_t_q  <= div_q;
                last_q   <= start_last;
                sclk_q   <= cpol_q;
                ss_q     <= sel_n;
            end
        end
    end

    always_comb begin
        D_out = '0;
        case (A)
            2'd0, 2'd1: D_out = rx_q;
            2'd2:       D_out = {cs_idx_q, 1'b0, overrun_q, ~&ss_q, busy};
            default:    D_out[DIV_W-1:0] = div_q;
        endcase
    end

    assign DDIR = !IORD;
    assign WAIT = !((busy || pend_q) && (IORD != IOWR));
    assign SS   = ss_q;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;

endmodule

// File: tb/tb_master_spi_multi.sv
// Directed bench for master_spi_multi: register table plus hand-written transfer sequences
// against a bus-driving host and a behavioural SPI slave/monitor.
module tb_master_spi_multi;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] A = 2'd0;
    logic [7:0] D_in = 8'd0;
    logic       IOWR = 1'b1;
    logic       IORD = 1'b1;
    logic       MISO = 1'b0;
    logic [7:0] D_out;
    logic       DDIR, WAIT, SCLK, MOSI;
    logic [3:0] SS;

    master_spi_multi #(.NCS(4), .DIV_W(8), .DEFAULT_DIV(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .A(A), .D_in(D_in), .D_out(D_out), .DDIR(DDIR),
        .WAIT(WAIT), .IOWR(IOWR), .IORD(IORD), .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor + slave model, all on the falling clock edge.
    int         mon_cyc = 0, mon_last = 0, mon_edges = 0, mon_ssl = 0;
    int         gap_min = 1000, gap_max = 0;
    logic [15:0] mon_rec = '0;
    logic       mon_sclk_prev = 1'b0;
    logic [3:0] mon_ss_prev = 4'hF;
    logic       sl_cpha = 1'b0;
    logic [7:0] sl_pat = 8'h00;

    always @(negedge CLK) begin
        int gap, k;
        mon_cyc++;
        if (SS != 4'hF) mon_ssl++;
        if (SS != 4'hF && mon_ss_prev == 4'hF) begin
            mon_last = mon_cyc;
            if (!sl_cpha) MISO = sl_pat[7];
        end
        if (SCLK !== mon_sclk_prev) begin
            mon_edges++;
            gap = mon_cyc - mon_last;
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
            mon_last = mon_cyc;
            if (mon_edges[0] != sl_cpha) mon_rec = {mon_rec[14:0], MOSI};
            k = mon_edges % 16;
            if (!sl_cpha && !mon_edges[0] && k != 0) MISO = sl_pat[7 - k / 2];
            if (sl_cpha && mon_edges[0]) MISO = sl_pat[7 - (k - 1) / 2];
        end
        mon_sclk_prev = SCLK;
        mon_ss_prev   = SS;
    end

    task automatic clear_mon(input logic cpha, input logic [7:0] pat);
        sl_cpha       = cpha;
        sl_pat        = pat;
        mon_edges     = 0;
        mon_ssl       = 0;
        mon_rec       = '0;
        gap_min       = 1000;
        gap_max       = 0;
        mon_last      = mon_cyc;
        mon_sclk_prev = SCLK;
        mon_ss_prev   = SS;
    endtask

    // One bus cycle: strobe low for 4 clocks, D_out and WAIT sampled mid-strobe.
    task automatic bus_op(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic wt);
        @(posedge CLK); #1;
        A    = a;
        D_in = d;
        if (wr) IOWR = 1'b0;
        else    IORD = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        rd = D_out;
        wt = WAIT;
        @(posedge CLK); #1;
        IOWR = 1'b1;
        IORD = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [1:0] a;
        logic [7:0] d;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic       exp_sclk;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rdv;
        logic       wtv;
        bit         hit;

        vecs[0]  = '{1'b0, 2'd3, 8'h00, 1'b1, 8'h03, 1'b0};
        vecs[1]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 8'h07, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 2'd3, 8'h00, 1'b1, 8'h07, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 8'h30, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h30, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 8'h92, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h30, 1'b0};
        vecs[9]  = '{1'b1, 2'd2, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[11] = '{1'b1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 8'h03, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 2'd3, 8'h00, 1'b1, 8'h03, 1'b0};

        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset SS", SS, 4'hF);
        chk("reset SCLK", SCLK, 1'b0);
        chk("reset MOSI", MOSI, 1'b0);
        chk("reset WAIT", WAIT, 1'b1);
        chk("reset DDIR", DDIR, 1'b0);

        for (int i = 0; i < NV; i++) begin
            bus_op(vecs[i].wr, vecs[i].a, vecs[i].d, rdv, wtv);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d rd", i), rdv, vecs[i].exp_rd);
            chk($sformatf("vec%0d sclk", i), SCLK, vecs[i].exp_sclk);
            chk($sformatf("vec%0d wait", i), wtv, 1'b1);
        end

        // Mode 0, DATA_LAST 0xA5, slave returns 0x3C.
        clear_mon(1'b0, 8'h3C);
        bus_op(1'b1, 2'd1, 8'hA5, rdv, wtv);
        repeat (80) @(posedge CLK);
        #1;
        chk("m0 edges", mon_edges, 16);
        chk("m0 gap min", gap_min, 4);
        chk("m0 gap max", gap_max, 4);
        chk("m0 mosi", mon_rec[7:0], 8'hA5);
        chk("m0 ss low cycles", mon_ssl, 68);
        chk("m0 ss after", SS, 4'hF);
        chk("m0 sclk after", SCLK, 1'b0);
        bus_op(1'b0, 2'd0, 8'h00, rdv, wtv);
        chk("m0 rx", rdv, 8'h3C);

        // Mode 3 on CS2, DATA_KEEP 0x81, slave returns 0x5A.
        bus_op(1'b1, 2'd2, 8'h23, rdv, wtv);
        chk("m3 sclk idle", SCLK, 1'b1);
        clear_mon(1'b1, 8'h5A);
        bus_op(1'b1, 2'd0, 8'h81, rdv, wtv);
        repeat (80) @(posedge CLK);
        #1;
        chk("m3 edges", mon_edges, 16);
        chk("m3 mosi", mon_rec[7:0], 8'h81);
        chk("m3 ss kept", SS, 4'b1011);
        chk("m3 sclk after", SCLK, 1'b1);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("m3 status held", rdv, 8'h22);
        bus_op(1'b0, 2'd1, 8'h00, rdv, wtv);
        chk("m3 rx", rdv, 8'h5A);
        chk("m3 ss released", SS, 4'hF);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("m3 status released", rdv, 8'h20);

        // Read-ahead: read A=0 returns old RX and launches a 0xFF transfer.
        bus_op(1'b1, 2'd2, 8'h04, rdv, wtv);
        chk("ar sclk idle", SCLK, 1'b0);
        clear_mon(1'b0, 8'hC3);
        bus_op(1'b0, 2'd0, 8'h00, rdv, wtv);
        chk("ar old rx", rdv, 8'h5A);
        bus_op(1'b0, 2'd3, 8'h00, rdv, wtv);
        chk("ar wait busy", wtv, 1'b0);
        chk("ar div read", rdv, 8'h03);
        repeat (80) @(posedge CLK);
        #1;
        chk("ar edges", mon_edges, 16);
        chk("ar mosi", mon_rec[7:0], 8'hFF);
        chk("ar ss kept", SS, 4'b1110);
        bus_op(1'b0, 2'd1, 8'h00, rdv, wtv);
        chk("ar rx", rdv, 8'hC3);
        chk("ar ss released", SS, 4'hF);
        bus_op(1'b1, 2'd2, 8'h00, rdv, wtv);

        // Pending slot and overrun.
        clear_mon(1'b0, 8'h00);
        bus_op(1'b1, 2'd1, 8'h11, rdv, wtv);
        bus_op(1'b1, 2'd1, 8'h22, rdv, wtv);
        chk("ov wait 2nd", wtv, 1'b0);
        bus_op(1'b1, 2'd1, 8'h33, rdv, wtv);
        chk("ov wait 3rd", wtv, 1'b0);
        repeat (200) @(posedge CLK);
        #1;
        chk("ov edges", mon_edges, 32);
        chk("ov mosi", mon_rec, 16'h1122);
        chk("ov ss low cycles", mon_ssl, 136);
        chk("ov ss after", SS, 4'hF);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("ov status 1", rdv, 8'h04);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("ov status 2", rdv, 8'h00);

        // Reset in the middle of a transfer, at SCLK edge 7.
        clear_mon(1'b0, 8'h00);
        bus_op(1'b1, 2'd1, 8'hF0, rdv, wtv);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge CLK);
            if (mon_edges == 7) hit = 1'b1;
        end
        chk("rst reached edge 7", hit, 1'b1);
        #1 RST_N = 1'b0;
        #1;
        chk("rst async SS", SS, 4'hF);
        chk("rst async SCLK", SCLK, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        clear_mon(1'b0, 8'h00);
        repeat (30) @(posedge CLK);
        #1;
        chk("rst no edges", mon_edges, 0);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("rst status", rdv, 8'h00);
        bus_op(1'b0, 2'd3, 8'h00, rdv, wtv);
        chk("rst div", rdv, 8'h03);

        // Both strobes low during a transfer: no command, WAIT stays high.
        clear_mon(1'b0, 8'h00);
        bus_op(1'b1, 2'd1, 8'h0F, rdv, wtv);
        @(posedge CLK); #1;
        A    = 2'd0;
        D_in = 8'h55;
        IOWR = 1'b0;
        IORD = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("both wait", WAIT, 1'b1);
        chk("both ddir", DDIR, 1'b1);
        @(posedge CLK); #1;
        IOWR = 1'b1;
        IORD = 1'b1;
        repeat (90) @(posedge CLK);
        #1;
        chk("both edges", mon_edges, 16);
        chk("both mosi", mon_rec[7:0], 8'h0F);
        bus_op(1'b0, 2'd2, 8'h00, rdv, wtv);
        chk("both status", rdv, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
